// File: rtl/multi_mode_ff_bank_pkg.sv
// Shared definitions for the multi-mode flip-flop bank: mode encodings and
// a legality helper used by the top level.
package mmff_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_D      = 3'd0;
    localparam logic [MODE_W-1:0] MODE_T      = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SR     = 3'd2;
    localparam logic [MODE_W-1:0] MODE_JK     = 3'd3;
    localparam logic [MODE_W-1:0] MODE_CNT_UP = 3'd4;
    localparam logic [MODE_W-1:0] MODE_CNT_DN = 3'd5;

    function automatic logic is_legal_mode(input logic [MODE_W-1:0] m);
        return (m <= MODE_CNT_DN);
    endfunction

endpackage

// File: rtl/multi_mode_ff_bank_cell.sv
// Single bit of the bank: computes the next state for D/T/SR/JK operation,
// or toggles under an external force in the counter modes.
module mm_ff_cell
    import mmff_pkg::*;
(
    input  logic              q,
    input  logic              a,
    input  logic              b,
    input  logic [MODE_W-1:0] mode,
    input  logic              tforce,
    output logic              q_next,
    output logic              sr_illegal
);

    // Illegal modes fall through to the default and simply hold the bit.
    always_comb begin
        q_next     = q;
        sr_illegal = 1'b0;
        case (mode)
            MODE_D: q_next = a;
            MODE_T: q_next = q ^ a;
            MODE_SR: begin
                case ({a, b})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   sr_illegal = 1'b1;
                    default: q_next = q;
                endcase
            end
            MODE_JK: begin
                case ({a, b})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   q_next = ~q;
                    default: q_next = q;
                endcase
            end
            MODE_CNT_UP, MODE_CNT_DN: q_next = q ^ tforce;
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH run-time configurable flip-flops that can also count up or
// down as a T-cell ripple-free synchronous counter, with sticky error flags.
module multi_mode_ff_bank
    import mmff_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               CNT_WRAP  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              clr_err,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qbar,
    output logic              tc,
    output logic [WIDTH-1:0]  sr_err,
    output logic              mode_err
);

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] sr_illegal;
    logic [WIDTH-1:0] tforce;
    logic [WIDTH-1:0] chain_up;
    logic [WIDTH-1:0] chain_dn;
    logic             is_up;
    logic             is_dn;
    logic             at_term;
    logic             mode_illegal;

    // Bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        chain_up    = '0;
        chain_dn    = '0;
        chain_up[0] = 1'b1;
        chain_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            chain_up[i] = chain_up[i-1] & q[i-1];
            chain_dn[i] = chain_dn[i-1] & ~q[i-1];
        end
    end

    assign is_up        = (mode == MODE_CNT_UP);
    assign is_dn        = (mode == MODE_CNT_DN);
    assign at_term      = (is_up && (&q)) || (is_dn && !(|q));
    assign mode_illegal = !is_legal_mode(mode);

    // Saturating builds suppress the terminal toggle so q sticks at the end value.
    always_comb begin
        tforce = '0;
        if (!(!CNT_WRAP && at_term)) begin
            if (is_up)
                tforce = chain_up;
            else if (is_dn)
                tforce = chain_dn;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        mm_ff_cell u_cell (
            .q          (q[g]),
            .a          (a[g]),
            .b          (b[g]),
            .mode       (mode),
            .tforce     (tforce[g]),
            .q_next     (q_next[g]),
            .sr_illegal (sr_illegal[g])
        );
    end

    assign qbar = ~q;
    assign tc   = en && at_term;

    // A clear in the same cycle as a fresh error keeps only the fresh error.
    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= RESET_VAL;
            sr_err   <= '0;
            mode_err <= 1'b0;
        end else begin
            if (en)
                q <= q_next;
            if (clr_err) begin
                sr_err   <= en ? sr_illegal : '0;
                mode_err <= en && mode_illegal;
            end else if (en) begin
                sr_err   <= sr_err | sr_illegal;
                mode_err <= mode_err | mode_illegal;
            end
        end
    end

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Scoreboard bench: a wrapping RESET_VAL=0 bank and a saturating RESET_VAL=9
// bank share stimulus and are checked against an arithmetic reference model.
module tb_multi_mode_ff_bank;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic         tc;
        logic [W-1:0] sr_err;
        logic         mode_err;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic [2:0]   mode = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         clr_err = 1'b0;

    logic [W-1:0] q0, qbar0, se0, q1, qbar1, se1;
    logic         tc0, me0, tc1, me1;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    logic [W-1:0] mq  [2];
    logic [W-1:0] mse [2];
    logic         mme [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multi_mode_ff_bank #(.WIDTH(W), .RESET_VAL(4'h0), .CNT_WRAP(1'b1)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
        .clr_err(clr_err), .q(q0), .qbar(qbar0), .tc(tc0), .sr_err(se0),
        .mode_err(me0)
    );

    multi_mode_ff_bank #(.WIDTH(W), .RESET_VAL(4'h9), .CNT_WRAP(1'b0)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
        .clr_err(clr_err), .q(q1), .qbar(qbar1), .tc(tc1), .sr_err(se1),
        .mode_err(me1)
    );

    // Reference model: flip-flop equations as whole-vector set/reset/toggle
    // masks and the counters as plain +1/-1 arithmetic with a terminal rule.
    function automatic exp_t step(input int k, input logic r, input logic e,
                                  input logic [2:0] m, input logic [W-1:0] aa,
                                  input logic [W-1:0] bb, input logic c);
        exp_t         x;
        logic [W-1:0] nq, set_m, rst_m, new_se;
        logic         new_me;
        bit           wrap;
        wrap  = (k == 0);
        set_m = aa & ~bb;
        rst_m = bb & ~aa;
        if (r) begin
            mq[k]  = (k == 0) ? 4'h0 : 4'h9;
            mse[k] = '0;
            mme[k] = 1'b0;
        end else begin
            nq     = mq[k];
            new_se = '0;
            new_me = 1'b0;
            if (e) begin
                case (m)
                    3'd0: nq = aa;
                    3'd1: nq = mq[k] ^ aa;
                    3'd2: begin
                        nq     = (mq[k] | set_m) & ~rst_m;
                        new_se = aa & bb;
                    end
                    3'd3: nq = ((mq[k] | set_m) & ~rst_m) ^ (aa & bb);
                    3'd4: nq = (mq[k] == 4'hF) ? (wrap ? 4'h0 : 4'hF) : mq[k] + 4'd1;
                    3'd5: nq = (mq[k] == 4'h0) ? (wrap ? 4'hF : 4'h0) : mq[k] - 4'd1;
                    default: new_me = 1'b1;
                endcase
            end
            if (c) begin
                mse[k] = new_se;
                mme[k] = new_me;
            end else begin
                mse[k] = mse[k] | new_se;
                mme[k] = mme[k] | new_me;
            end
            mq[k] = nq;
        end
        x.q        = mq[k];
        x.tc       = e && ((m == 3'd4 && mq[k] == 4'hF) || (m == 3'd5 && mq[k] == 4'h0));
        x.sr_err   = mse[k];
        x.mode_err = mme[k];
        return x;
    endfunction

    task automatic applyStimulus(input logic r, input logic e, input logic [2:0] m,
                                 input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic c);
        @(negedge clk);
        reset   = r;
        en      = e;
        mode    = m;
        a       = aa;
        b       = bb;
        clr_err = c;
        exp_q0.push_back(step(0, r, e, m, aa, bb, c));
        exp_q1.push_back(step(1, r, e, m, aa, bb, c));
    endtask

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t x, input logic [W-1:0] qa,
                               input logic [W-1:0] qba, input logic tca,
                               input logic [W-1:0] sea, input logic mea);
        cmp({tag, ".q"},        qa, x.q);
        cmp({tag, ".qbar"},     qba, ~x.q);
        cmp({tag, ".tc"},       {3'b0, tca}, {3'b0, x.tc});
        cmp({tag, ".sr_err"},   sea, x.sr_err);
        cmp({tag, ".mode_err"}, {3'b0, mea}, {3'b0, x.mode_err});
    endtask

    // Monitor: every edge with an outstanding expectation is checked #1 later.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q0.size() > 0) begin
                x = exp_q0.pop_front();
                checkOutput("wrap", x, q0, qbar0, tc0, se0, me0);
            end
            if (exp_q1.size() > 0) begin
                x = exp_q1.pop_front();
                checkOutput("sat", x, q1, qbar1, tc1, se1, me1);
            end
        end
    end

    initial begin
        int burst;
        logic [2:0] m;
        // Reset, then reset again out of a loaded value.
        applyStimulus(1, 0, 3'd0, 4'h0, 4'h0, 0);
        applyStimulus(0, 1, 3'd0, 4'hA, 4'h0, 0);
        applyStimulus(1, 1, 3'd0, 4'h5, 4'h0, 0);
        // T mode toggling, then hold with en low.
        applyStimulus(0, 1, 3'd0, 4'h0, 4'h0, 0);
        applyStimulus(0, 1, 3'd1, 4'b0101, 4'h0, 0);
        applyStimulus(0, 1, 3'd1, 4'b0101, 4'h0, 0);
        applyStimulus(0, 0, 3'd1, 4'b0101, 4'h0, 0);
        // SR with one illegal bit, then clear.
        applyStimulus(0, 1, 3'd2, 4'b0011, 4'b0110, 0);
        applyStimulus(0, 1, 3'd2, 4'h0, 4'h0, 1);
        // New SR errors in the same cycle as a clear, and clear with en low.
        applyStimulus(0, 1, 3'd2, 4'hC, 4'hC, 0);
        applyStimulus(0, 1, 3'd2, 4'h3, 4'h3, 1);
        applyStimulus(0, 0, 3'd2, 4'hF, 4'hF, 1);
        // JK all-toggle.
        applyStimulus(0, 1, 3'd0, 4'h3, 4'h0, 0);
        applyStimulus(0, 1, 3'd3, 4'hF, 4'hF, 0);
        // Count up through the terminal value.
        applyStimulus(0, 1, 3'd0, 4'hE, 4'h0, 0);
        applyStimulus(0, 1, 3'd4, 4'h0, 4'h0, 0);
        applyStimulus(0, 1, 3'd4, 4'h0, 4'h0, 0);
        applyStimulus(0, 1, 3'd4, 4'h0, 4'h0, 0);
        applyStimulus(0, 0, 3'd4, 4'h0, 4'h0, 0);
        // Count down through zero, then illegal mode and reset.
        applyStimulus(0, 1, 3'd0, 4'h1, 4'h0, 0);
        applyStimulus(0, 1, 3'd5, 4'h0, 4'h0, 0);
        applyStimulus(0, 1, 3'd5, 4'h0, 4'h0, 0);
        applyStimulus(0, 1, 3'd7, 4'h0, 4'h0, 0);
        applyStimulus(0, 1, 3'd6, 4'h0, 4'h0, 0);
        applyStimulus(1, 1, 3'd6, 4'h0, 4'h0, 0);

        // Random bursts of one mode so the counters reach their terminal values.
        for (int it = 0; it < 60; it++) begin
            m     = 3'($urandom_range(0, 7));
            burst = $urandom_range(1, 20);
            for (int j = 0; j < burst; j++) begin
                applyStimulus(($urandom_range(0, 49) == 0),
                              ($urandom_range(0, 99) < 85),
                              m, 4'($urandom), 4'($urandom),
                              ($urandom_range(0, 9) == 0));
            end
        end

        for (int i = 0; i < 10 && (exp_q0.size() > 0 || exp_q1.size() > 0); i++)
            @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: %0d/%0d expectations left, expected 0",
                     exp_q0.size(), exp_q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
